// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequencer around a one-bit add cell (two half adders
// plus a carry flip-flop). Operands are captured on start and stepped
// LSB-first, one bit per clock; the WIDTH-bit sum and carry-out are
// presented with a one-cycle done strobe.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // Counter only has to reach WIDTH-1, so ceil(log2(WIDTH)) bits suffice.
   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic [CW-1:0] ZERO = CW'(0);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ADD  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] a_sr_r;
   logic [WIDTH-1:0] b_sr_r;
   logic [WIDTH-1:0] res_sr_r;
   logic             carry_r;
   logic [CW-1:0]    cnt_r;

   logic [1:0]       ha0_s;
   logic [1:0]       ha1_s;
   logic             s_bit_s;
   logic             carry_nxt_s;
   logic [WIDTH-1:0] res_nxt_s;

   // Half adder: returns {carry, sum}.
   function automatic logic [1:0] half_add(input logic x, input logic y);
      return {x & y, x ^ y};
   endfunction

   // One-bit add cell: first half adder on the operand bits, second with
   // the stored carry; either stage generating a carry produces carry-out.
   always_comb begin
      ha0_s       = half_add(a_sr_r[0], b_sr_r[0]);
      ha1_s       = half_add(ha0_s[0], carry_r);
      s_bit_s     = ha1_s[0];
      carry_nxt_s = ha0_s[1] | ha1_s[1];
      res_nxt_s   = {s_bit_s, res_sr_r[WIDTH-1:1]};
   end

   // Sequencer FSM with datapath registers and registered outputs; reset wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         a_sr_r   <= '0;
         b_sr_r   <= '0;
         res_sr_r <= '0;
         carry_r  <= 1'b0;
         cnt_r    <= ZERO;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr_r  <= a;
                  b_sr_r  <= b;
                  carry_r <= 1'b0;
                  cnt_r   <= ZERO;
                  busy    <= 1'b1;
                  state_r <= ADD;
               end else begin
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            ADD: begin
               a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
               b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
               res_sr_r <= res_nxt_s;
               carry_r  <= carry_nxt_s;
               if (cnt_r == LAST) begin
                  // Last bit: publish the completed result including this bit.
                  cnt_r   <= ZERO;
                  sum     <= res_nxt_s;
                  cout    <= carry_nxt_s;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= DONE;
               end else begin
                  cnt_r   <= cnt_r + ONE;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  state_r <= ADD;
               end
            end
            DONE: begin
               // Single-cycle strobe; start is not looked at here.
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               cnt_r   <= ZERO;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks for serial_add_ctrl at WIDTH=8 and WIDTH=16.
module tb_serial_add_ctrl;

   logic        clk;
   logic        rst;
   logic        start8;
   logic [7:0]  a8, b8, sum8;
   logic        busy8, done8, cout8;
   logic        start16;
   logic [15:0] a16, b16, sum16;
   logic        busy16, done16, cout16;

   int n_checks;
   int n_fail;

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_add_ctrl #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Run one 8-bit op; returns result and negedge index at which done rose
   // (index 1 is the first negedge after the accepting edge).
   task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                      output logic [7:0] s, output logic c, output int lat);
      @(negedge clk);
      a8 = av; b8 = bv; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      lat = 1;
      while (done8 !== 1'b1 && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      n_checks++;
      if (done8 !== 1'b1) begin
         n_fail++;
         $display("FAIL op8_timeout: done=%b required 1", done8);
      end
      s = sum8; c = cout8;
   endtask

   task automatic op16(input logic [15:0] av, input logic [15:0] bv,
                       output logic [15:0] s, output logic c, output int lat);
      @(negedge clk);
      a16 = av; b16 = bv; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      lat = 1;
      while (done16 !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      n_checks++;
      if (done16 !== 1'b1) begin
         n_fail++;
         $display("FAIL op16_timeout: done=%b required 1", done16);
      end
      s = sum16; c = cout16;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({busy8, done8, cout8, sum8} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset8: busy/done/cout/sum=%b required 0", {busy8, done8, cout8, sum8});
      end
      n_checks++;
      if ({busy16, done16, cout16, sum16} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset16: busy/done/cout/sum=%b required 0", {busy16, done16, cout16, sum16});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      @(negedge clk);
      a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         start8 = 1'b0;
         a8 = 8'h00; b8 = 8'h00;   // operands may change after capture
         n_checks++;
         if (busy8 !== (i <= 8) || done8 !== (i == 9)) begin
            n_fail++;
            $display("FAIL basic_timing cycle %0d: busy=%b done=%b required busy=%b done=%b",
                     i, busy8, done8, (i <= 8), (i == 9));
         end
         if (i == 9) begin
            n_checks++;
            if (sum8 !== 8'h96 || cout8 !== 1'b0) begin
               n_fail++;
               $display("FAIL basic_result: sum=%h cout=%b required 96 0", sum8, cout8);
            end
         end
      end
   endtask

   task automatic test_carry();
      logic [7:0] s;
      logic       c;
      int         lat;
      op8(8'hFF, 8'h01, s, c, lat);
      n_checks++;
      if ({c, s} !== 9'h100 || lat != 9) begin
         n_fail++;
         $display("FAIL carry_ff_01: cout/sum=%h lat=%0d required 100 lat 9", {c, s}, lat);
      end
      op8(8'hFF, 8'hFF, s, c, lat);
      n_checks++;
      if ({c, s} !== 9'h1FE) begin
         n_fail++;
         $display("FAIL carry_ff_ff: cout/sum=%h required 1fe", {c, s});
      end
      op8(8'h00, 8'h00, s, c, lat);
      n_checks++;
      if ({c, s} !== 9'h000) begin
         n_fail++;
         $display("FAIL carry_cleared: cout/sum=%h required 000", {c, s});
      end
   endtask

   task automatic test_ignore_start();
      int dones;
      dones = 0;
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
      for (int i = 1; i <= 25; i++) begin
         @(negedge clk);
         start8 = 1'b0;
         if (done8 === 1'b1) dones++;
         if (i == 9) begin
            n_checks++;
            if (done8 !== 1'b1 || sum8 !== 8'h30 || cout8 !== 1'b0) begin
               n_fail++;
               $display("FAIL ignore_result: done=%b sum=%h cout=%b required 1 30 0", done8, sum8, cout8);
            end
         end
         if (i == 3 || i == 9) begin
            a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
         end
      end
      n_checks++;
      if (dones != 1 || busy8 !== 1'b0 || sum8 !== 8'h30) begin
         n_fail++;
         $display("FAIL ignore_single_done: dones=%0d busy=%b sum=%h required 1 0 30", dones, busy8, sum8);
      end
   endtask

   task automatic test_reset_abort();
      logic [7:0] s;
      logic       c;
      int         lat;
      int         dones;
      dones = 0;
      @(negedge clk);
      a8 = 8'hAB; b8 = 8'hCD; start8 = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         start8 = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_state: busy=%b done=%b sum=%h cout=%b required 0 0 00 0",
                  busy8, done8, sum8, cout8);
      end
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done8 === 1'b1) dones++;
      end
      n_checks++;
      if (dones != 0) begin
         n_fail++;
         $display("FAIL abort_no_done: dones=%0d required 0", dones);
      end
      op8(8'h01, 8'h02, s, c, lat);
      n_checks++;
      if ({c, s} !== 9'h003) begin
         n_fail++;
         $display("FAIL abort_fresh_op: cout/sum=%h required 003", {c, s});
      end
   endtask

   task automatic test_back_to_back();
      int last;
      int dones;
      logic prev;
      last = 0; dones = 0; prev = 1'b0;
      @(negedge clk);
      a8 = 8'h0F; b8 = 8'h01; start8 = 1'b1;
      for (int i = 1; i <= 45; i++) begin
         @(negedge clk);
         n_checks++;
         if (prev === 1'b1 && done8 === 1'b1) begin
            n_fail++;
            $display("FAIL b2b_double_done cycle %0d: done=1 twice, required single", i);
         end
         if (done8 === 1'b1) begin
            dones++;
            n_checks++;
            if (sum8 !== 8'h10 || cout8 !== 1'b0 || (i - last) != ((last == 0) ? 9 : 10)) begin
               n_fail++;
               $display("FAIL b2b_done cycle %0d: sum=%h cout=%b gap=%0d required 10 0 gap %0d",
                        i, sum8, cout8, i - last, (last == 0) ? 9 : 10);
            end
            last = i;
         end
         prev = done8;
      end
      start8 = 1'b0;
      n_checks++;
      if (dones != 4) begin
         n_fail++;
         $display("FAIL b2b_count: dones=%0d required 4", dones);
      end
      repeat (12) @(negedge clk);
   endtask

   task automatic test_random();
      logic [7:0]  s8, ra8, rb8;
      logic [15:0] s16, ra16, rb16;
      logic        c;
      int          lat;
      for (int i = 0; i < 1000; i++) begin
         ra8 = 8'($urandom); rb8 = 8'($urandom);
         op8(ra8, rb8, s8, c, lat);
         n_checks++;
         if ({c, s8} !== ({1'b0, ra8} + {1'b0, rb8}) || lat != 9) begin
            n_fail++;
            $display("FAIL rand8 %h+%h: got %h lat %0d required %h lat 9",
                     ra8, rb8, {c, s8}, lat, {1'b0, ra8} + {1'b0, rb8});
         end
      end
      for (int i = 0; i < 1000; i++) begin
         ra16 = 16'($urandom); rb16 = 16'($urandom);
         op16(ra16, rb16, s16, c, lat);
         n_checks++;
         if ({c, s16} !== ({1'b0, ra16} + {1'b0, rb16}) || lat != 17) begin
            n_fail++;
            $display("FAIL rand16 %h+%h: got %h lat %0d required %h lat 17",
                     ra16, rb16, {c, s16}, lat, {1'b0, ra16} + {1'b0, rb16});
         end
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      rst = 1'b1;
      start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      start16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
      test_reset();
      test_basic();
      test_carry();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer for a bit-serial adder built around a single one-bit add cell (two half-adder stages plus a carry flip-flop).
- Accepts two WIDTH-bit operands on a start pulse and steps them LSB-first through the add cell, one bit per clock.
- Reports the WIDTH-bit sum and carry-out with a one-cycle done strobe.
- Lets the team reuse the one-bit adder datapath for multi-bit addition, trading latency for area.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge only.
- b  input  WIDTH  operand B; captured on the accepting edge only.
- busy  output  1  high while the addition is in progress (ADD state).
- done  output  1  one-cycle strobe: sum and cout valid.
- sum  output  WIDTH  registered result, a+b mod 2^WIDTH.
- cout  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE; busy=0; done=0; sum=0; cout=0; carry FF=0; bit counter=0; operand shift registers=0.
- Reset has priority over every other event, including mid-ADD and during DONE. The in-flight operation is discarded and no done is issued.
- States:
  - IDLE: busy=0, done=0. If start=1 at an edge: load a_sr<=a, b_sr<=b, carry<=0, cnt<=0, go to ADD. Otherwise stay in IDLE.
  - ADD: busy=1. Each edge:
    - s_bit = a_sr[0]^b_sr[0]^carry, formed by a half adder on a_sr[0],b_sr[0] followed by a half adder with carry.
    - carry <= (a_sr[0]&b_sr[0]) | (carry&(a_sr[0]^b_sr[0])).
    - Shift res_sr right with s_bit entering the MSB; shift a_sr and b_sr right with 0 entering.
    - cnt <= cnt+1.
    - On the edge where cnt==WIDTH-1: sum <= final res_sr (including this bit), cout <= new carry, go to DONE.
  - DONE: done=1, busy=0 for exactly one cycle, then IDLE unconditionally.
- Latency: start accepted at edge E0; done is high in the cycle after edge E0+WIDTH. This is a WIDTH-cycle latency, i.e. 8 cycles at the default WIDTH.
- Throughput: a new start is accepted no earlier than the edge that leaves DONE. The minimum start-to-start period is WIDTH+2 cycles.
- start while busy=1 or done=1 is ignored: no queueing, and the operand capture is unaffected.
- a and b may change freely after the accepting edge without affecting the result.
- sum and cout hold their last result until the next DONE transition or reset. They are not cleared on start.
- Wrap-around: the result is modulo 2^WIDTH; overflow is reported only via cout.
- Counter width is ceil(log2(WIDTH)) bits. The counter never exceeds WIDTH-1.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h3C, start pulse in IDLE -> busy=1 for 8 cycles; done high exactly 8 cycles after the accepting edge; sum=8'h96, cout=0.
- a=8'hFF, b=8'h01 -> sum=8'h00, cout=1 (full carry ripple). Then a=8'hFF, b=8'hFF -> sum=8'hFE, cout=1. Then a=0, b=0 -> sum=8'h00, cout=0 (carry FF cleared between ops).
- Start accepted with a=8'h10, b=8'h20; re-assert start with a=8'hFF, b=8'hFF on cycles 3 and 9 after acceptance (during ADD and during DONE) -> only one done; sum=8'h30, cout=0; second start ignored, state IDLE afterwards.
- Assert rst on cycle 4 of ADD -> next cycle busy=0, done=0, sum=0, cout=0. No done ever appears for the aborted op, and a fresh op 8'h01+8'h02 then yields 8'h03.
- Back-to-back: start held high continuously with a=8'h0F, b=8'h01 -> done pulses every 10 cycles; sum=8'h10 each time; done is never high two cycles in a row.
- Random regression, 1000 ops at WIDTH=8 and WIDTH=16, compared against a reference model of {cout,sum}=a+b -> zero mismatches.
